coeff_loader: RTL
=================

COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 SHALL have parameter W, default 32, fixed-point coefficient width.
REQ-002 SHALL have parameter FRAC, default 30, fractional bits; output format Q(W-FRAC).FRAC signed.
REQ-003 SHALL have port clk_fast, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports b0, b1, b2, a1, a2, input, 64 each, IEEE-754 double coefficient set from the coefficient generator.
REQ-006 SHALL have port done, input, 1, coefficient set valid in this cycle.
REQ-007 SHALL have port sample_tick, input, 1, filter sample boundary; the only time the active set may change.
REQ-008 SHALL have ports c_b0, c_b1, c_b2, c_a1, c_a2, output, W each, active fixed-point coefficients, registered.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port swapped, output, 1, one-cycle pulse coincident with the first cycle new active values are visible.
REQ-011 SHALL have port sat_flag, output, 1, high if the currently active set contained a saturated or NaN input; updated only on swap.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse, cycle after a done that was dropped.

Function
REQ-013 SHALL latch all five doubles into capture registers on the cycle done is accepted (cycle T).
REQ-014 SHALL implement FSM IDLE -> CONV -> PEND -> IDLE.
REQ-015 In CONV, SHALL convert one coefficient per cycle, order b0, b1, b2, a1, a2, cycles T+1..T+5, through a single shared converter, writing a shadow bank.
REQ-016 SHALL enter PEND at T+6 and hold the shadow bank until sample_tick.
REQ-017 On sample_tick high in PEND at cycle S, active outputs SHALL update, swapped SHALL pulse, and sat_flag SHALL update at S+1; state -> IDLE.
REQ-018 Conversion: result = round(x * 2^FRAC), rounding half away from zero on magnitude, then sign applied.
REQ-019 Exponent field 0 (zero/denormal) SHALL yield 0, no saturation.
REQ-020 Magnitude >= 2^(W-1-FRAC) after rounding SHALL saturate: positive -> 2^(W-1)-1, negative -> -2^(W-1); exactly -2^(W-1-FRAC) is exact, not saturated.
REQ-021 Infinity SHALL saturate by sign; NaN SHALL yield 0; both mark the set saturated.
REQ-022 done in IDLE: accepted.
REQ-023 done in CONV: ignored, overrun pulses next cycle, conversion continues unaffected.
REQ-024 done in PEND without sample_tick: accepted, pending shadow set discarded, restart CONV (latest wins).
REQ-025 done and sample_tick together in PEND: pending set SHALL swap and the new set SHALL be accepted into CONV.
REQ-026 sample_tick outside PEND SHALL have no effect.

Reset
REQ-027 rst SHALL force state IDLE, c_b0 = 2^FRAC (1.0; 0x40000000 at default), c_b1 = c_b2 = c_a1 = c_a2 = 0, busy/swapped/sat_flag/overrun = 0, shadow bank cleared.
REQ-028 rst SHALL take priority over done and sample_tick in the same cycle; a set in CONV or PEND is discarded.

Verification
REQ-029 Reset: assert rst 2 cycles -> c_b0 = 0x40000000, others 0, busy = 0, swapped = 0.
REQ-030 Nominal: done with b0 = 0x3FD0000000000000 (0.25), b1 = 0x3FE0000000000000 (0.5), b2 = 0x3E00000000000000 (2^-31), a1 = 0xBFF0000000000000 (-1.0), a2 = 0x3FE0000000000000; sample_tick at T+10 -> at T+11: 0x10000000, 0x20000000, 0x00000001, 0xC0000000, 0x20000000; swapped pulse; sat_flag = 0; outputs unchanged T..T+10.
REQ-031 Saturation: b0 = 0x4008000000000000 (3.0), a1 = 0xC004000000000000 (-2.5), a2 = 0x7FF8000000000000 (NaN), others 0 -> after swap c_b0 = 0x7FFFFFFF, c_a1 = 0x80000000, c_a2 = 0, sat_flag = 1.
REQ-032 Overrun: done at T and T+3 -> overrun pulse at T+4; after tick, first set active.
REQ-033 Latest wins / simultaneous: set A pending, done(set B) with sample_tick at S -> A active at S+1; B swaps on next tick after S+6.
REQ-034 Reset mid-operation: rst at T+3 -> reset values held, busy = 0 at T+4, later sample_tick produces no swap.

Source files
------------

// File: rtl/coeff_loader.sv
// coeff_loader
//
// Takes a biquad coefficient set (b0, b1, b2, a1, a2) in IEEE-754 double form,
// converts it to signed Q(W-FRAC).FRAC fixed point one coefficient per cycle
// through a single shared converter, and holds the result in a shadow bank.
// The shadow bank becomes the active set only on a filter sample boundary, so
// the filter never sees a partially updated set.
//
// Parameters
//   W     fixed-point coefficient width
//   FRAC  number of fractional bits
//
// Ports
//   clk_fast               sole clock, rising edge
//   rst                    synchronous active-high reset
//   b0, b1, b2, a1, a2     double-precision coefficient set
//   done                   coefficient set valid this cycle
//   sample_tick            filter sample boundary
//   c_b0 .. c_a2           active fixed-point coefficients (registered)
//   busy                   high whenever the loader is not idle
//   swapped                one-cycle pulse when a new active set appears
//   sat_flag               active set contained a saturated/NaN/Inf input
//   overrun                one-cycle pulse, cycle after a dropped done

module coeff_loader #(
    parameter int W    = 32,
    parameter int FRAC = 30
) (
    input  logic         clk_fast,
    input  logic         rst,
    input  logic [63:0]  b0,
    input  logic [63:0]  b1,
    input  logic [63:0]  b2,
    input  logic [63:0]  a1,
    input  logic [63:0]  a2,
    input  logic         done,
    input  logic         sample_tick,
    output logic [W-1:0] c_b0,
    output logic [W-1:0] c_b1,
    output logic [W-1:0] c_b2,
    output logic [W-1:0] c_a1,
    output logic [W-1:0] c_a2,
    output logic         busy,
    output logic         swapped,
    output logic         sat_flag,
    output logic         overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        PEND = 2'd2
    } state_t;

    // Working width of the converter: wide enough to hold the 53-bit
    // significand plus any left shift that still fits below saturation.
    localparam int EW = W + 54;

    localparam logic [EW-1:0] HALF  = {{(EW-1){1'b0}}, 1'b1} << (W-1);
    localparam logic [W-1:0]  QMAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  QMIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  Q_ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

    state_t state;
    state_t state_next;

    logic [63:0]  cap [5];
    logic [W-1:0] shadow [5];
    logic         shadow_sat;
    logic [2:0]   idx;

    logic         accept;
    logic         swap;

    logic [63:0]  conv_in;
    logic [10:0]  conv_exp;
    logic         conv_sign;
    int           conv_pos;
    logic [EW-1:0] conv_ext;
    logic [EW-1:0] conv_tmp;
    logic [EW-1:0] conv_mag;
    logic [EW-1:0] conv_neg;
    logic [W-1:0] conv_out;
    logic         conv_sat;

    // A new set can be taken whenever no conversion is in flight; a pending
    // set is simply overwritten (latest wins). Swap happens only from PEND.
    assign accept = done && ((state == IDLE) || (state == PEND));
    assign swap   = sample_tick && (state == PEND);

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (done) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (idx == 3'd4) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (done) begin
                    state_next = CONV;
                end else if (sample_tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    assign conv_in = cap[idx];

    // Double -> fixed conversion. conv_pos is the bit position the implicit
    // leading one lands on after scaling by 2^FRAC. Below -1 the value is
    // under 0.5 and rounds to zero; at or above W it is certainly out of range.
    // For the right-shift case we shift one bit short so the last bit shifted
    // out is available as the half-LSB round bit (half away from zero on the
    // magnitude, sign applied afterwards).
    always_comb begin
        conv_exp  = conv_in[62:52];
        conv_sign = conv_in[63];
        conv_ext  = {{(EW-53){1'b0}}, 1'b1, conv_in[51:0]};
        conv_pos  = int'(conv_exp) - 1023 + FRAC;
        conv_tmp  = '0;
        conv_mag  = '0;
        conv_neg  = '0;
        conv_out  = '0;
        conv_sat  = 1'b0;

        if (conv_exp == 11'h7FF) begin
            conv_sat = 1'b1;
            if (conv_in[51:0] == 52'd0) begin
                conv_out = conv_sign ? QMIN : QMAX;
            end
        end else if (conv_exp != 11'd0) begin
            if (conv_pos >= W) begin
                conv_sat = 1'b1;
                conv_out = conv_sign ? QMIN : QMAX;
            end else if (conv_pos >= -1) begin
                if (conv_pos >= 52) begin
                    conv_mag = conv_ext << (conv_pos - 52);
                end else begin
                    conv_tmp = conv_ext >> (51 - conv_pos);
                    conv_mag = (conv_tmp >> 1) + {{(EW-1){1'b0}}, conv_tmp[0]};
                end

                // -2^(W-1) is representable exactly, +2^(W-1) is not.
                if (!conv_sign && (conv_mag >= HALF)) begin
                    conv_sat = 1'b1;
                    conv_out = QMAX;
                end else if (conv_sign && (conv_mag > HALF)) begin
                    conv_sat = 1'b1;
                    conv_out = QMIN;
                end else begin
                    conv_neg = -conv_mag;
                    conv_out = conv_sign ? conv_neg[W-1:0] : conv_mag[W-1:0];
                end
            end
        end
    end

    // Capture, shadow bank fill and active-bank swap. On a simultaneous
    // swap + accept the active bank takes the old shadow contents while the
    // capture registers load the new set, so both happen in one edge.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                cap[i]    <= '0;
                shadow[i] <= '0;
            end
            shadow_sat <= 1'b0;
            idx        <= '0;
            c_b0       <= Q_ONE;
            c_b1       <= '0;
            c_b2       <= '0;
            c_a1       <= '0;
            c_a2       <= '0;
            swapped    <= 1'b0;
            sat_flag   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            swapped <= swap;
            overrun <= done && (state == CONV);

            if (swap) begin
                c_b0     <= shadow[0];
                c_b1     <= shadow[1];
                c_b2     <= shadow[2];
                c_a1     <= shadow[3];
                c_a2     <= shadow[4];
                sat_flag <= shadow_sat;
            end

            if (accept) begin
                cap[0]     <= b0;
                cap[1]     <= b1;
                cap[2]     <= b2;
                cap[3]     <= a1;
                cap[4]     <= a2;
                idx        <= '0;
                shadow_sat <= 1'b0;
            end else if (state == CONV) begin
                shadow[idx] <= conv_out;
                shadow_sat  <= shadow_sat | conv_sat;
                idx         <= idx + 3'd1;
            end
        end
    end

endmodule
